fex_seq: RTL and testbench



---
 rtl/wi23_defs.sv | 28 ++
 rtl/fex_seq.sv | 145 ++++++++++++++
 tb/tb_fex_seq.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wi23_defs.sv
// Shared definitions for the wi23 core.
// Holds register file sizing and the FP execute sequencer types.
package wi23_defs;

   localparam int REGFILE_DEPTH = 5;

   typedef enum logic [2:0] {
      FADD    = 3'd0,
      FSUB    = 3'd1,
      FMUL    = 3'd2,
      FDIV    = 3'd3,
      FCVT_IF = 3'd4,
      FCVT_FI = 3'd5,
      FMOV    = 3'd6
   } fex_op_t;

   localparam int FEX_ADD_LAT = 3;
   localparam int FEX_MUL_LAT = 4;
   localparam int FEX_DIV_LAT = 12;
   localparam int FEX_CVT_LAT = 2;

   typedef enum logic [1:0] {
      FEX_IDLE = 2'd0,
      FEX_RUN  = 2'd1,
      FEX_DONE = 2'd2
   } fex_state_t;

endpackage

// File: rtl/fex_seq.sv
// FP execute sequencer: counts op latency, holds writeback control
// until granted, and feeds busy/early-release to decode hazard logic.
module fex_seq
   import wi23_defs::*;
#(
   parameter int ADD_LAT = FEX_ADD_LAT,
   parameter int MUL_LAT = FEX_MUL_LAT,
   parameter int DIV_LAT = FEX_DIV_LAT,
   parameter int CVT_LAT = FEX_CVT_LAT
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     issue_vld,
   input  logic [2:0]               issue_op,
   input  logic [REGFILE_DEPTH-1:0] issue_regw,
   input  logic                     issue_ctrl_regw,
   input  logic [1:0]               issue_cvt,
   input  logic                     issue_kill,
   input  logic                     wb_ready,
   output logic                     dp_start,
   output logic [2:0]               dp_op,
   output logic                     busy,
   output logic                     busy_er,
   output logic [REGFILE_DEPTH-1:0] fex_regw,
   output logic                     fex_ctrl_regw,
   output logic [1:0]               fex_cvt,
   output logic                     wb_vld,
   output logic [REGFILE_DEPTH-1:0] wb_regw,
   output logic                     wb_ctrl_regw,
   output logic [1:0]               wb_cvt
);

   localparam int MAXL_AM = (ADD_LAT > MUL_LAT) ? ADD_LAT : MUL_LAT;
   localparam int MAXL_DC = (DIV_LAT > CVT_LAT) ? DIV_LAT : CVT_LAT;
   localparam int MAXL    = (MAXL_AM > MAXL_DC) ? MAXL_AM : MAXL_DC;
   localparam int CW      = (MAXL > 1) ? $clog2(MAXL) : 1;

   if (ADD_LAT < 1 || MUL_LAT < 1 || DIV_LAT < 1 || CVT_LAT < 1)
   begin : g_lat_chk
      $error("fex_seq: all latencies must be >= 1");
   end

   // Undefined opcodes fall back to the conversion latency.
   function automatic logic [CW-1:0] lat_m1(input logic [2:0] op);
      logic [CW-1:0] v;
      case (op)
         FADD, FSUB: v = CW'(ADD_LAT - 1);
         FMUL:       v = CW'(MUL_LAT - 1);
         FDIV:       v = CW'(DIV_LAT - 1);
         default:    v = CW'(CVT_LAT - 1);
      endcase
      return v;
   endfunction

   fex_state_t               r_state;
   fex_state_t               w_state_nxt;
   logic [CW-1:0]            r_cnt;
   logic [CW-1:0]            w_cnt_nxt;
   logic [2:0]               r_op;
   logic [REGFILE_DEPTH-1:0] r_regw;
   logic                     r_ctrl_regw;
   logic [1:0]               r_cvt;
   logic                     r_start;
   logic                     w_acc;
   logic                     w_wb_vld;
   logic                     w_busy_er;

   assign w_wb_vld  = (r_state == FEX_RUN && r_cnt == '0) ||
                      (r_state == FEX_DONE);
   assign w_busy_er = w_wb_vld & wb_ready;
   assign w_acc     = issue_vld & ~issue_kill &
                      ((r_state == FEX_IDLE) | w_busy_er);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         FEX_IDLE: begin
            if (w_acc) begin
               w_state_nxt = FEX_RUN;
               w_cnt_nxt   = lat_m1(issue_op);
            end
         end
         FEX_RUN: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - 1'b1;
            end else if (wb_ready) begin
               w_state_nxt = w_acc ? FEX_RUN : FEX_IDLE;
               if (w_acc) w_cnt_nxt = lat_m1(issue_op);
            end else begin
               w_state_nxt = FEX_DONE;
            end
         end
         FEX_DONE: begin
            if (wb_ready) begin
               w_state_nxt = w_acc ? FEX_RUN : FEX_IDLE;
               if (w_acc) w_cnt_nxt = lat_m1(issue_op);
            end
         end
         default: begin
            w_state_nxt = FEX_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= FEX_IDLE;
         r_cnt   <= '0;
         r_start <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_start <= w_acc;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_op        <= '0;
         r_regw      <= '0;
         r_ctrl_regw <= 1'b0;
         r_cvt       <= '0;
      end else if (w_acc) begin
         r_op        <= issue_op;
         r_regw      <= issue_regw;
         r_ctrl_regw <= issue_ctrl_regw;
         r_cvt       <= issue_cvt;
      end
   end

   assign busy          = (r_state != FEX_IDLE);
   assign busy_er       = w_busy_er;
   assign dp_start      = r_start;
   assign dp_op         = r_op;
   assign fex_regw      = r_regw;
   assign fex_ctrl_regw = r_ctrl_regw & busy;
   assign fex_cvt       = r_cvt;
   assign wb_vld        = w_wb_vld;
   assign wb_regw       = fex_regw;
   assign wb_ctrl_regw  = fex_ctrl_regw;
   assign wb_cvt        = fex_cvt;

endmodule

// File: tb/tb_fex_seq.sv
// Directed bench for fex_seq: latency, stalls, back-to-back, kill,
// mid-op reset and illegal-issue handling.
module tb_fex_seq;
   import wi23_defs::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       issue_vld;
   logic [2:0] issue_op;
   logic [4:0] issue_regw;
   logic       issue_ctrl_regw;
   logic [1:0] issue_cvt;
   logic       issue_kill;
   logic       wb_ready;
   logic       dp_start;
   logic [2:0] dp_op;
   logic       busy;
   logic       busy_er;
   logic [4:0] fex_regw;
   logic       fex_ctrl_regw;
   logic [1:0] fex_cvt;
   logic       wb_vld;
   logic [4:0] wb_regw;
   logic       wb_ctrl_regw;
   logic [1:0] wb_cvt;

   int checks = 0;
   int errors = 0;
   int n_illegal = 0;

   fex_seq dut (
      .clk(clk), .rst_n(rst_n),
      .issue_vld(issue_vld), .issue_op(issue_op),
      .issue_regw(issue_regw), .issue_ctrl_regw(issue_ctrl_regw),
      .issue_cvt(issue_cvt), .issue_kill(issue_kill),
      .wb_ready(wb_ready), .dp_start(dp_start), .dp_op(dp_op),
      .busy(busy), .busy_er(busy_er), .fex_regw(fex_regw),
      .fex_ctrl_regw(fex_ctrl_regw), .fex_cvt(fex_cvt),
      .wb_vld(wb_vld), .wb_regw(wb_regw),
      .wb_ctrl_regw(wb_ctrl_regw), .wb_cvt(wb_cvt)
   );

   always #5 clk = ~clk;

   // Issues while busy and not releasing are protocol violations.
   always @(negedge clk)
      if (rst_n && issue_vld && busy && !busy_er) n_illegal++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] op, input logic [4:0] rw,
                        input logic cr, input logic [1:0] cv);
      issue_vld = 1'b1; issue_op = op; issue_regw = rw;
      issue_ctrl_regw = cr; issue_cvt = cv;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; issue_vld = 0; issue_op = 0; issue_regw = 0;
      issue_ctrl_regw = 0; issue_cvt = 0; issue_kill = 0; wb_ready = 0;
      tick(); tick();
      checks++;
      if ({busy, busy_er, dp_start, wb_vld} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags got=%b exp=0000",
                  {busy, busy_er, dp_start, wb_vld});
      end
      checks++;
      if ({dp_op, fex_regw, fex_ctrl_regw, fex_cvt} !== 11'b0) begin
         errors++;
         $display("FAIL reset_fields got=%h exp=0",
                  {dp_op, fex_regw, fex_ctrl_regw, fex_cvt});
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({busy, wb_vld, wb_regw, wb_ctrl_regw, wb_cvt} !== 10'b0) begin
         errors++;
         $display("FAIL post_reset got=%h exp=0",
                  {busy, wb_vld, wb_regw, wb_ctrl_regw, wb_cvt});
      end
   endtask

   task automatic test_fmul();
      wb_ready = 1'b1;
      drive(FMUL, 5'd7, 1'b1, 2'b00);
      tick();
      issue_vld = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         checks++;
         if ({busy, dp_start, wb_vld} !==
             {1'(k <= 4), 1'(k == 1), 1'(k == 4)}) begin
            errors++;
            $display("FAIL fmul_seq k=%0d got=%b exp=%b", k,
                     {busy, dp_start, wb_vld},
                     {1'(k <= 4), 1'(k == 1), 1'(k == 4)});
         end
         if (k == 1) begin
            checks++;
            if ({dp_op, fex_regw, fex_ctrl_regw} !== {FMUL, 5'd7, 1'b1}) begin
               errors++;
               $display("FAIL fmul_fields got=%h exp=%h",
                        {dp_op, fex_regw, fex_ctrl_regw},
                        {FMUL, 5'd7, 1'b1});
            end
         end
         tick();
      end
   endtask

   task automatic test_fdiv_stall();
      wb_ready = 1'b0;
      drive(FDIV, 5'd9, 1'b1, 2'b01);
      tick();
      issue_vld = 1'b0;
      for (int k = 1; k <= 18; k++) begin
         if (k == 17) wb_ready = 1'b1;
         #1;
         checks++;
         if ({busy, wb_vld} !== {1'(k <= 17), 1'(k >= 12 && k <= 17)}) begin
            errors++;
            $display("FAIL fdiv_stall k=%0d got=%b exp=%b", k,
                     {busy, wb_vld}, {1'(k <= 17), 1'(k >= 12 && k <= 17)});
         end
         if (k >= 12 && k <= 17) begin
            checks++;
            if ({wb_regw, wb_ctrl_regw, wb_cvt, busy_er} !==
                {5'd9, 1'b1, 2'b01, 1'(k == 17)}) begin
               errors++;
               $display("FAIL fdiv_hold k=%0d got=%h exp=%h", k,
                        {wb_regw, wb_ctrl_regw, wb_cvt, busy_er},
                        {5'd9, 1'b1, 2'b01, 1'(k == 17)});
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      int wb_cnt = 0;
      wb_ready = 1'b1;
      drive(FADD, 5'd3, 1'b1, 2'b00);
      tick();
      issue_vld = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         if (k == 3) drive(FMUL, 5'd5, 1'b1, 2'b00);
         #1;
         if (wb_vld) wb_cnt++;
         checks++;
         if ({busy, wb_vld} !== {1'(k <= 7), 1'(k == 3 || k == 7)}) begin
            errors++;
            $display("FAIL b2b k=%0d got=%b exp=%b", k, {busy, wb_vld},
                     {1'(k <= 7), 1'(k == 3 || k == 7)});
         end
         if (k == 3 || k == 4) begin
            checks++;
            if ({fex_regw, busy_er, dp_start} !==
                {(k == 3) ? 5'd3 : 5'd5, 1'(k == 3), 1'(k == 4)}) begin
               errors++;
               $display("FAIL b2b_switch k=%0d got=%h exp=%h", k,
                        {fex_regw, busy_er, dp_start},
                        {(k == 3) ? 5'd3 : 5'd5, 1'(k == 3), 1'(k == 4)});
            end
         end
         tick();
         issue_vld = 1'b0;
      end
      checks++;
      if (wb_cnt !== 2) begin
         errors++;
         $display("FAIL b2b_wb_count got=%0d exp=2", wb_cnt);
      end
   endtask

   task automatic test_kill();
      wb_ready = 1'b1;
      drive(FADD, 5'd1, 1'b1, 2'b00);
      issue_kill = 1'b1;
      tick();
      issue_vld = 1'b0; issue_kill = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if ({busy, dp_start, wb_vld} !== 3'b000) begin
            errors++;
            $display("FAIL kill_idle k=%0d got=%b exp=000", k,
                     {busy, dp_start, wb_vld});
         end
         tick();
      end
      drive(FDIV, 5'd4, 1'b1, 2'b00);
      tick();
      issue_vld = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         issue_kill = (k >= 2 && k <= 5);
         #1;
         checks++;
         if ({busy, wb_vld, busy_er} !==
             {1'(k <= 12), 1'(k == 12), 1'(k == 12)}) begin
            errors++;
            $display("FAIL kill_fdiv k=%0d got=%b exp=%b", k,
                     {busy, wb_vld, busy_er},
                     {1'(k <= 12), 1'(k == 12), 1'(k == 12)});
         end
         tick();
      end
      issue_kill = 1'b0;
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      wb_ready = 1'b1;
      drive(FDIV, 5'd6, 1'b1, 2'b01);
      tick();
      issue_vld = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, wb_vld, dp_start, dp_op, fex_regw, fex_ctrl_regw, fex_cvt}
          !== 14'b0) begin
         errors++;
         $display("FAIL rst_mid got=%h exp=0",
                  {busy, wb_vld, dp_start, dp_op, fex_regw,
                   fex_ctrl_regw, fex_cvt});
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 14; k++) begin
         if (wb_vld || busy) stray++;
         tick();
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL rst_no_wb got=%0d exp=0", stray);
      end
      drive(FCVT_FI, 5'd2, 1'b1, 2'b10);
      tick();
      issue_vld = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         checks++;
         if ({busy, dp_start, wb_vld} !==
             {1'(k <= 2), 1'(k == 1), 1'(k == 2)}) begin
            errors++;
            $display("FAIL cvt_seq k=%0d got=%b exp=%b", k,
                     {busy, dp_start, wb_vld},
                     {1'(k <= 2), 1'(k == 1), 1'(k == 2)});
         end
         if (k == 2) begin
            checks++;
            if ({fex_cvt, wb_cvt, wb_regw} !== {2'b10, 2'b10, 5'd2}) begin
               errors++;
               $display("FAIL cvt_fields got=%h exp=%h",
                        {fex_cvt, wb_cvt, wb_regw}, {2'b10, 2'b10, 5'd2});
            end
         end
         tick();
      end
   endtask

   task automatic test_illegal();
      int base = n_illegal;
      wb_ready = 1'b1;
      drive(FMUL, 5'd8, 1'b1, 2'b00);
      tick();
      drive(FADD, 5'd12, 1'b0, 2'b11);
      tick();
      issue_vld = 1'b0;
      checks++;
      if ({dp_start, dp_op, fex_regw, fex_ctrl_regw, fex_cvt} !==
          {1'b0, FMUL, 5'd8, 1'b1, 2'b00}) begin
         errors++;
         $display("FAIL illegal_ignored got=%h exp=%h",
                  {dp_start, dp_op, fex_regw, fex_ctrl_regw, fex_cvt},
                  {1'b0, FMUL, 5'd8, 1'b1, 2'b00});
      end
      tick(); tick();
      checks++;
      if ({wb_vld, wb_regw} !== {1'b1, 5'd8}) begin
         errors++;
         $display("FAIL illegal_wb got=%h exp=%h",
                  {wb_vld, wb_regw}, {1'b1, 5'd8});
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL illegal_idle got=%b exp=0", busy);
      end
      checks++;
      if (n_illegal - base !== 1) begin
         errors++;
         $display("FAIL illegal_count got=%0d exp=1", n_illegal - base);
      end
   endtask

   initial begin
      test_reset();
      test_fmul();
      test_fdiv_stall();
      test_back_to_back();
      test_kill();
      test_reset_mid();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
